// File: rtl/alu_pkg.sv
// Shared op encodings and FSM state type for seq_alu.
// SEQ_ALU_DIV_EN: when defined, DIVU/REMU are iterative; otherwise they are undefined ops.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_LUI   = 4'd11,
        OP_MUL   = 4'd12,
        OP_MULHU = 4'd13,
        OP_DIVU  = 4'd14,
        OP_REMU  = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    function automatic logic is_iterative(input alu_op_t op);
`ifdef SEQ_ALU_DIV_EN
        return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
`else
        return op inside {OP_MUL, OP_MULHU};
`endif
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 shift-add multiplier and restoring divider sharing one accumulator.
// SEQ_ALU_DIV_EN: when undefined the divide step is not built.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_flush,
    input  alu_op_t          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_hi;
    logic               r_busy;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [2*WIDTH-1:0] w_nxt;
    logic               w_last;

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
    logic               r_div;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [2*WIDTH-1:0] w_div_nxt;

    // Divide: acc = {remainder, dividend/quotient}; a zero divisor always subtracts,
    // which naturally yields all-ones quotient and remainder = dividend.
    assign w_shift   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_rem_sub = w_shift[WIDTH-1:0] - r_opb;
    assign w_div_nxt = (w_shift >= {1'b0, r_opb})
                     ? {w_rem_sub, r_acc[WIDTH-2:0], 1'b1}
                     : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    assign w_nxt     = r_div ? w_div_nxt : w_mul_nxt;
`else
    assign w_nxt     = w_mul_nxt;
`endif

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign o_busy   = r_busy;
    assign o_done   = r_busy && w_last;
    assign o_result = r_hi ? w_nxt[2*WIDTH-1:WIDTH] : w_nxt[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_opb  <= '0;
            r_hi   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            r_div  <= 1'b0;
`endif
        end else if (i_flush) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_acc  <= {{WIDTH{1'b0}}, i_a};
            r_opb  <= i_b;
            r_hi   <= (i_op == OP_MULHU) || (i_op == OP_REMU);
`ifdef SEQ_ALU_DIV_EN
            r_div  <= (i_op == OP_DIVU) || (i_op == OP_REMU);
`endif
        end else if (r_busy) begin
            r_acc <= w_nxt;
            if (w_last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle ops plus iterative MUL/MULHU (and DIVU/REMU
// when SEQ_ALU_DIV_EN is defined); result held until the consumer takes it.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_t       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    alu_op_t          w_op;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu;
    logic             w_accept;
    logic             w_start;
    logic             w_md_busy;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_result;

    assign w_op      = alu_op_t'(op);
    assign w_shamt   = op2[SHW-1:0];
    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_start   = w_accept && is_iterative(w_op);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = w_md_busy;

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = op1 + op2;
            OP_SUB:  w_alu = op1 - op2;
            OP_AND:  w_alu = op1 & op2;
            OP_OR:   w_alu = op1 | op2;
            OP_XOR:  w_alu = op1 ^ op2;
            OP_NOR:  w_alu = ~(op1 | op2);
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            OP_SLL:  w_alu = op1 << w_shamt;
            OP_SRL:  w_alu = op1 >> w_shamt;
            OP_SRA:  w_alu = $unsigned($signed(op1) >>> w_shamt);
            OP_LUI:  w_alu = {op2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: w_alu = '0;
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_flush  (flush),
        .i_op     (w_op),
        .i_a      (op1),
        .i_b      (op2),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_BUSY: begin
                    if (w_md_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_md_result;
                    end
                end
                default: begin
                    if (w_start) begin
                        r_state     <= ST_BUSY;
                        r_out_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_alu;
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32); honours SEQ_ALU_DIV_EN for divide expectations.
module tb_seq_alu;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                           NOR_ = 4'd5, SLT = 4'd6, SLTU = 4'd7, SLL = 4'd8, SRL = 4'd9,
                           SRA = 4'd10, LUI = 4'd11, MUL = 4'd12, MULHU = 4'd13,
                           DIVU = 4'd14, REMU = 4'd15;
`ifdef SEQ_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;
    int          checks = 0, failures = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .op1(op1), .op2(op2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            ADD:   return a + b;
            SUB:   return a - b;
            AND_:  return a & b;
            OR_:   return a | b;
            XOR_:  return a ^ b;
            NOR_:  return ~(a | b);
            SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU:  return (a < b) ? 32'd1 : 32'd0;
            SLL:   return a << b[4:0];
            SRL:   return a >> b[4:0];
            SRA:   return $unsigned($signed(a) >>> b[4:0]);
            LUI:   return {b[15:0], 16'h0000};
            MUL:   return p[31:0];
            MULHU: return p[63:32];
            DIVU:  return !DIV_EN ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return !DIV_EN ? 32'd0 : (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] o);
        if (o == MUL || o == MULHU || (DIV_EN && (o == DIVU || o == REMU))) return 33;
        return 1;
    endfunction

    // Issue one request from IDLE, scramble inputs after accept, wait (bounded) for the result, retire it.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cyc);
        op = o; op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'($urandom); op1 = $urandom; op2 = $urandom;
        lat = 1; busy_cyc = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: out_valid=%b busy=%b result=%h in_ready=%b, want 0 0 0 1",
                     out_valid, busy, result, in_ready);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    typedef struct { logic [3:0] o; logic [31:0] a; logic [31:0] b; logic [31:0] e; } vec_t;

    task automatic test_directed();
        vec_t v[$];
        logic [31:0] res;
        int lat, bc, exp_lat;
        v.push_back('{ADD,   32'hFFFF_FFFF, 32'd1,        32'd0});
        v.push_back('{SLT,   32'hFFFF_FFFF, 32'd1,        32'd1});
        v.push_back('{SLTU,  32'hFFFF_FFFF, 32'd1,        32'd0});
        v.push_back('{SRA,   32'h8000_0000, 32'd4,        32'hF800_0000});
        v.push_back('{SLL,   32'd3,         32'h21,       32'd6});
        v.push_back('{SUB,   32'd0,         32'd1,        32'hFFFF_FFFF});
        v.push_back('{NOR_,  32'd0,         32'd0,        32'hFFFF_FFFF});
        v.push_back('{LUI,   32'd0,         32'hABCD_1234, 32'h1234_0000});
        v.push_back('{MUL,   32'h1_0000,    32'h1_0000,   32'd0});
        v.push_back('{MULHU, 32'h1_0000,    32'h1_0000,   32'd1});
        v.push_back('{DIVU,  32'd100,       32'd7,        DIV_EN ? 32'd14 : 32'd0});
        v.push_back('{REMU,  32'd100,       32'd7,        DIV_EN ? 32'd2 : 32'd0});
        v.push_back('{DIVU,  32'h1234_5678, 32'd0,        DIV_EN ? 32'hFFFF_FFFF : 32'd0});
        v.push_back('{REMU,  32'd5,         32'd0,        DIV_EN ? 32'd5 : 32'd0});
        foreach (v[i]) begin
            run_op(v[i].o, v[i].a, v[i].b, res, lat, bc);
            exp_lat = model_lat(v[i].o);
            checks++;
            if (res !== v[i].e) begin
                failures++;
                $display("FAIL directed_result[%0d] op=%0d: got %h want %h", i, v[i].o, res, v[i].e);
            end
            checks++;
            if (lat != exp_lat || bc != exp_lat - 1) begin
                failures++;
                $display("FAIL directed_timing[%0d] op=%0d: latency=%0d busy=%0d want %0d %0d",
                         i, v[i].o, lat, bc, exp_lat, exp_lat - 1);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [31:0] a, b, res;
        int lat, bc;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op(o, a, b, res, lat, bc);
            checks++;
            if (res !== model(o, a, b) || lat != model_lat(o)) begin
                failures++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                         i, o, a, b, res, lat, model(o, a, b), model_lat(o));
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        op = ADD; op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        op1 = $urandom; op2 = $urandom;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== a + b) begin
                failures++;
                $display("FAIL hold[%0d]: out_valid=%b in_ready=%b result=%h want 1 0 %h",
                         i, out_valid, in_ready, result, a + b);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_retire: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            op = ADD; op1 = a; op2 = b; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== a + b) begin
                failures++;
                $display("FAIL back_to_back[%0d]: out_valid=%b result=%h want 1 %h",
                         i, out_valid, result, a + b);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        bit seen;
        op = ADD; op1 = 32'd1; op2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_vs_accept: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        op = MUL; op1 = $urandom; op2 = $urandom; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_mul: busy=%b out_valid=%b in_ready=%b want 0 0 1",
                     busy, out_valid, in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL flush_quiet: activity seen=%b want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        op = MUL; op1 = $urandom; op2 = $urandom; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: busy=%b out_valid=%b result=%h in_ready=%b want 0 0 0 1",
                     busy, out_valid, result, in_ready);
        end
        #1 rst_n = 1'b1;
        a = $urandom; b = $urandom;
        op = ADD; op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== a + b) begin
            failures++;
            $display("FAIL reset_mid_add: out_valid=%b result=%h want 1 %h", out_valid, result, a + b);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
